// File: rtl/phy_lane_scoreboard_if.sv
// -----------------------------------------------------------------------------
// phy_lane_scoreboard_if
// Purpose : bundles the stimulus and result signals of the N-lane PHY
//           scoreboard so the bench and the checker share one port object.
// Modports: master - bench side, drives the i_* signals and observes o_*
//           slave  - scoreboard side, reads i_* and drives o_*
// Signals : i_enable, i_ref_valid/i_ref_data, i_dut_valid/i_dut_data,
//           o_match_cnt, o_mismatch_cnt, o_missing_cnt, o_overflow, o_error,
//           o_first_err_lane/exp/got, o_busy, o_done
//           o_lane_err_cnt only when PHY_SCOREBOARD_LANE_CNT_EN is defined.
// -----------------------------------------------------------------------------
interface phy_lane_scoreboard_if #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8,
  parameter int CNT_W     = 16
);
  logic                          i_enable;
  logic [NUM_LANES-1:0]          i_ref_valid;
  logic [NUM_LANES*DATA_W-1:0]   i_ref_data;
  logic [NUM_LANES-1:0]          i_dut_valid;
  logic [NUM_LANES*DATA_W-1:0]   i_dut_data;
  logic [CNT_W-1:0]              o_match_cnt;
  logic [CNT_W-1:0]              o_mismatch_cnt;
  logic [CNT_W-1:0]              o_missing_cnt;
  logic [NUM_LANES-1:0]          o_overflow;
  logic                          o_error;
  logic [3:0]                    o_first_err_lane;
  logic [DATA_W-1:0]             o_first_err_exp;
  logic [DATA_W-1:0]             o_first_err_got;
  logic                          o_busy;
  logic                          o_done;
`ifdef PHY_SCOREBOARD_LANE_CNT_EN
  logic [NUM_LANES*CNT_W-1:0]    o_lane_err_cnt;
`endif

  modport master (
    output i_enable, i_ref_valid, i_ref_data, i_dut_valid, i_dut_data,
    input  o_match_cnt, o_mismatch_cnt, o_missing_cnt, o_overflow, o_error,
           o_first_err_lane, o_first_err_exp, o_first_err_got, o_busy, o_done
`ifdef PHY_SCOREBOARD_LANE_CNT_EN
           , o_lane_err_cnt
`endif
  );

  modport slave (
    input  i_enable, i_ref_valid, i_ref_data, i_dut_valid, i_dut_data,
    output o_match_cnt, o_mismatch_cnt, o_missing_cnt, o_overflow, o_error,
           o_first_err_lane, o_first_err_exp, o_first_err_got, o_busy, o_done
`ifdef PHY_SCOREBOARD_LANE_CNT_EN
           , o_lane_err_cnt
`endif
  );
endinterface

// File: rtl/phy_lane_scoreboard.sv
// -----------------------------------------------------------------------------
// phy_lane_scoreboard
// Purpose : N-lane self-checking scoreboard. Reference-model bytes are queued
//           per lane in a DEPTH-entry skew FIFO; each implementation beat on a
//           lane pops the head of that lane's FIFO and compares. Counts
//           matches, mismatches and unmatched leftovers, flags overflow, keeps
//           a sticky error and captures the first failing beat.
// Ports   : clk   - single rising-edge clock
//           reset - synchronous, active-high
//           bus   - phy_lane_scoreboard_if.slave (inputs i_*, results o_*)
// Option  : PHY_SCOREBOARD_LANE_CNT_EN adds per-lane saturating mismatch
//           counters on bus.o_lane_err_cnt (lane i at [i*CNT_W +: CNT_W]).
// -----------------------------------------------------------------------------
module phy_lane_scoreboard #(
  parameter int NUM_LANES = 4,
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int CNT_W     = 16,
  parameter int FLUSH_TO  = 64
) (
  input logic                   clk,
  input logic                   reset,
  phy_lane_scoreboard_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int FW = $clog2(FLUSH_TO + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH} state_t;

  state_t               r_state;
  logic [DATA_W-1:0]    r_mem [NUM_LANES][DEPTH];
  logic [AW-1:0]        r_rdPtr [NUM_LANES];
  logic [AW-1:0]        r_wrPtr [NUM_LANES];
  logic [AW:0]          r_count [NUM_LANES];
  logic [CNT_W-1:0]     r_matchCnt;
  logic [CNT_W-1:0]     r_mismatchCnt;
  logic [CNT_W-1:0]     r_missingCnt;
  logic [NUM_LANES-1:0] r_overflow;
  logic                 r_error;
  logic                 r_capValid;
  logic [3:0]           r_firstLane;
  logic [DATA_W-1:0]    r_firstExp;
  logic [DATA_W-1:0]    r_firstGot;
  logic                 r_busy;
  logic                 r_done;
  logic [FW-1:0]        r_flushCnt;

  logic [DATA_W-1:0]    w_refByte [NUM_LANES];
  logic [DATA_W-1:0]    w_dutByte [NUM_LANES];
  logic [DATA_W-1:0]    w_head    [NUM_LANES];
  logic [DATA_W-1:0]    w_exp     [NUM_LANES];
  logic [AW:0]          w_cntNext [NUM_LANES];
  logic [NUM_LANES-1:0] w_empty, w_full, w_pushReq, w_popReq, w_bypass;
  logic [NUM_LANES-1:0] w_fifoPush, w_fifoPop, w_ovf, w_match, w_mis;
  logic [31:0]          w_matchInc, w_misInc, w_missingInc;
  logic                 w_allEmptyNext;
  logic                 w_flushExit;
  logic [3:0]           w_misLane;
  logic [DATA_W-1:0]    w_misExp, w_misGot;

  // Saturating add so a long run pins the counters at all-ones rather than
  // wrapping back to a small, misleading number.
  function automatic logic [CNT_W-1:0] satAdd(input logic [CNT_W-1:0] a,
                                              input logic [31:0] b);
    logic [CNT_W+32:0] s;
    s = {33'd0, a} + {{(CNT_W+1){1'b0}}, b};
    if (s > {33'd0, {CNT_W{1'b1}}}) return {CNT_W{1'b1}};
    return s[CNT_W-1:0];
  endfunction

  // Per-lane datapath. An empty FIFO with a same-cycle ref push is compared
  // directly against the incoming ref byte and never stored. A full FIFO may
  // still accept a push when the same cycle pops, because the pop frees the
  // slot. A dut beat with nothing to compare against is a mismatch with an
  // expected value of zero.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    assign w_refByte[g]  = bus.i_ref_data[g*DATA_W +: DATA_W];
    assign w_dutByte[g]  = bus.i_dut_data[g*DATA_W +: DATA_W];
    assign w_head[g]     = r_mem[g][r_rdPtr[g]];
    assign w_empty[g]    = (r_count[g] == '0);
    assign w_full[g]     = (r_count[g] == (AW+1)'(DEPTH));
    assign w_pushReq[g]  = (r_state == S_RUN) && bus.i_ref_valid[g];
    assign w_popReq[g]   = (r_state != S_IDLE) && bus.i_dut_valid[g];
    assign w_bypass[g]   = w_popReq[g] && w_empty[g] && w_pushReq[g];
    assign w_fifoPop[g]  = w_popReq[g] && !w_empty[g];
    assign w_fifoPush[g] = w_pushReq[g] && !w_bypass[g] && (!w_full[g] || w_fifoPop[g]);
    assign w_ovf[g]      = w_pushReq[g] && w_full[g] && !w_popReq[g];
    assign w_exp[g]      = !w_empty[g] ? w_head[g] :
                           (w_bypass[g] ? w_refByte[g] : '0);
    assign w_match[g]    = w_popReq[g] && (!w_empty[g] || w_bypass[g]) &&
                           (w_exp[g] == w_dutByte[g]);
    assign w_mis[g]      = w_popReq[g] && !w_match[g];
    assign w_cntNext[g]  = r_count[g] + (AW+1)'(w_fifoPush[g]) - (AW+1)'(w_fifoPop[g]);
  end

  // Event totals across lanes, flush exit decision, and selection of the
  // lowest mismatching lane (the loop runs downwards so the lowest lane is
  // the last write and wins).
  always_comb begin
    w_matchInc     = '0;
    w_misInc       = '0;
    w_missingInc   = '0;
    w_allEmptyNext = 1'b1;
    w_misLane      = '0;
    w_misExp       = '0;
    w_misGot       = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--) begin
      w_matchInc   = w_matchInc + 32'(w_match[i]);
      w_misInc     = w_misInc + 32'(w_mis[i]);
      w_missingInc = w_missingInc + 32'(w_cntNext[i]);
      if (w_cntNext[i] != '0) w_allEmptyNext = 1'b0;
      if (w_mis[i]) begin
        w_misLane = 4'(i);
        w_misExp  = w_exp[i];
        w_misGot  = w_dutByte[i];
      end
    end
    w_flushExit = (r_state == S_FLUSH) &&
                  (w_allEmptyNext || (r_flushCnt == FW'(FLUSH_TO - 1)));
  end

  // FIFO storage. Data slots carry no reset; only pointers and occupancy
  // decide what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (w_fifoPush[i]) r_mem[i][r_wrPtr[i]] <= w_refByte[i];
    end
  end

  // FIFO pointers and occupancy. Leaving FLUSH empties every lane so the
  // next run starts clean; leftovers have already been counted as missing.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (reset || w_flushExit) begin
        r_rdPtr[i] <= '0;
        r_wrPtr[i] <= '0;
        r_count[i] <= '0;
      end else begin
        if (w_fifoPush[i]) r_wrPtr[i] <= r_wrPtr[i] + AW'(1);
        if (w_fifoPop[i])  r_rdPtr[i] <= r_rdPtr[i] + AW'(1);
        r_count[i] <= w_cntNext[i];
      end
    end
  end

  // Control FSM with registered busy/done plus the result counters, sticky
  // flags and first-failure capture. Reset aborts a run on the spot, so done
  // only ever pulses on a genuine FLUSH to IDLE exit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_flushCnt    <= '0;
      r_matchCnt    <= '0;
      r_mismatchCnt <= '0;
      r_missingCnt  <= '0;
      r_overflow    <= '0;
      r_error       <= 1'b0;
      r_capValid    <= 1'b0;
      r_firstLane   <= '0;
      r_firstExp    <= '0;
      r_firstGot    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.i_enable) begin
            r_state <= S_RUN;
            r_busy  <= 1'b1;
          end
        end
        S_RUN: begin
          if (!bus.i_enable) begin
            r_state    <= S_FLUSH;
            r_flushCnt <= '0;
          end
        end
        S_FLUSH: begin
          r_flushCnt <= r_flushCnt + FW'(1);
          if (w_flushExit) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      r_matchCnt    <= satAdd(r_matchCnt, w_matchInc);
      r_mismatchCnt <= satAdd(r_mismatchCnt, w_misInc);
      if (w_flushExit) r_missingCnt <= satAdd(r_missingCnt, w_missingInc);
      r_overflow <= r_overflow | w_ovf;

      if ((w_misInc != '0) || (|w_ovf) || (w_flushExit && (w_missingInc != '0)))
        r_error <= 1'b1;

      if (!r_capValid && (|w_mis)) begin
        r_capValid  <= 1'b1;
        r_firstLane <= w_misLane;
        r_firstExp  <= w_misExp;
        r_firstGot  <= w_misGot;
      end
    end
  end

`ifdef PHY_SCOREBOARD_LANE_CNT_EN
  logic [CNT_W-1:0] r_laneErrCnt [NUM_LANES];

  // Optional per-lane mismatch counters, updated on the same edge as the
  // aggregate mismatch counter.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (reset) r_laneErrCnt[i] <= '0;
      else       r_laneErrCnt[i] <= satAdd(r_laneErrCnt[i], 32'(w_mis[i]));
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_laneCnt
    assign bus.o_lane_err_cnt[g*CNT_W +: CNT_W] = r_laneErrCnt[g];
  end
`endif

  assign bus.o_match_cnt      = r_matchCnt;
  assign bus.o_mismatch_cnt   = r_mismatchCnt;
  assign bus.o_missing_cnt    = r_missingCnt;
  assign bus.o_overflow       = r_overflow;
  assign bus.o_error          = r_error;
  assign bus.o_first_err_lane = r_firstLane;
  assign bus.o_first_err_exp  = r_firstExp;
  assign bus.o_first_err_got  = r_firstGot;
  assign bus.o_busy           = r_busy;
  assign bus.o_done           = r_done;

endmodule

// File: tb/tb_phy_lane_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_phy_lane_scoreboard
// Drives a 4-lane scoreboard and a twin with 4-bit counters from the same
// stimulus. A table of per-cycle vectors covers a clean skewed run, a queued
// mismatch and a bypass match; hand-written sequences cover overflow with
// flush timeout, reset mid-run, empty-FIFO dut beats and full-FIFO push/pop.
// -----------------------------------------------------------------------------
module tb_phy_lane_scoreboard;

  localparam int NL = 4;
  localparam int DW = 8;
  localparam int CW = 16;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  phy_lane_scoreboard_if #(.NUM_LANES(NL), .DATA_W(DW), .CNT_W(CW)) bus ();
  phy_lane_scoreboard_if #(.NUM_LANES(NL), .DATA_W(DW), .CNT_W(4))  satBus ();

  phy_lane_scoreboard #(.NUM_LANES(NL), .DATA_W(DW), .DEPTH(4), .CNT_W(CW), .FLUSH_TO(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  phy_lane_scoreboard #(.NUM_LANES(NL), .DATA_W(DW), .DEPTH(4), .CNT_W(4), .FLUSH_TO(64)) satDut (
    .clk   (clk),
    .reset (reset),
    .bus   (satBus)
  );

  // The saturation twin mirrors every input of the main instance.
  assign satBus.i_enable    = bus.i_enable;
  assign satBus.i_ref_valid = bus.i_ref_valid;
  assign satBus.i_ref_data  = bus.i_ref_data;
  assign satBus.i_dut_valid = bus.i_dut_valid;
  assign satBus.i_dut_data  = bus.i_dut_data;

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [3:0]  rv;
    logic [31:0] rd;
    logic [3:0]  dv;
    logic [31:0] dd;
    int          expMatch;
    int          expMis;
    logic        expErr;
    logic        expBusy;
    logic        expDone;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mkVec(logic en, logic [3:0] rv, logic [31:0] rd,
                                 logic [3:0] dv, logic [31:0] dd, int m, int mm,
                                 logic e, logic b, logic d);
    vec_t v;
    v.en = en; v.rv = rv; v.rd = rd; v.dv = dv; v.dd = dd;
    v.expMatch = m; v.expMis = mm; v.expErr = e; v.expBusy = b; v.expDone = d;
    return v;
  endfunction

  // Drive one cycle of inputs at the falling edge and return just after the
  // next falling edge, so outputs are sampled half a cycle after the update.
  task automatic applyStimulus(input logic en, input logic [3:0] rv, input logic [31:0] rd,
                               input logic [3:0] dv, input logic [31:0] dd);
    bus.i_enable    = en;
    bus.i_ref_valid = rv;
    bus.i_ref_data  = rd;
    bus.i_dut_valid = dv;
    bus.i_dut_data  = dd;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAllClear(input string tag);
    checkOutput({tag, "_match"},    32'(bus.o_match_cnt), 0);
    checkOutput({tag, "_mismatch"}, 32'(bus.o_mismatch_cnt), 0);
    checkOutput({tag, "_missing"},  32'(bus.o_missing_cnt), 0);
    checkOutput({tag, "_overflow"}, 32'(bus.o_overflow), 0);
    checkOutput({tag, "_error"},    32'(bus.o_error), 0);
    checkOutput({tag, "_lane"},     32'(bus.o_first_err_lane), 0);
    checkOutput({tag, "_busy"},     32'(bus.o_busy), 0);
    checkOutput({tag, "_done"},     32'(bus.o_done), 0);
  endtask

  initial begin
    int n;
    bit seen;
    checks   = 0;
    failures = 0;

    // Skewed clean run (dut 2 cycles behind), then a queued lane-2 mismatch,
    // then a same-cycle bypass match on an empty lane 0.
    vecs[0]  = mkVec(1, 4'h0, 32'h0,        4'h0, 32'h0,         0, 0, 0, 1, 0);
    vecs[1]  = mkVec(1, 4'hF, 32'h13121110, 4'h0, 32'h0,         0, 0, 0, 1, 0);
    vecs[2]  = mkVec(1, 4'hF, 32'h17161514, 4'h0, 32'h0,         0, 0, 0, 1, 0);
    vecs[3]  = mkVec(1, 4'hF, 32'h1B1A1918, 4'hF, 32'h13121110,  4, 0, 0, 1, 0);
    vecs[4]  = mkVec(1, 4'hF, 32'h1F1E1D1C, 4'hF, 32'h17161514,  8, 0, 0, 1, 0);
    vecs[5]  = mkVec(1, 4'h0, 32'h0,        4'hF, 32'h1B1A1918, 12, 0, 0, 1, 0);
    vecs[6]  = mkVec(1, 4'h0, 32'h0,        4'hF, 32'h1F1E1D1C, 16, 0, 0, 1, 0);
    vecs[7]  = mkVec(0, 4'h0, 32'h0,        4'h0, 32'h0,        16, 0, 0, 1, 0);
    vecs[8]  = mkVec(0, 4'h0, 32'h0,        4'h0, 32'h0,        16, 0, 0, 0, 1);
    vecs[9]  = mkVec(0, 4'h0, 32'h0,        4'h0, 32'h0,        16, 0, 0, 0, 0);
    vecs[10] = mkVec(1, 4'h0, 32'h0,        4'h0, 32'h0,        16, 0, 0, 1, 0);
    vecs[11] = mkVec(1, 4'h4, 32'h005A0000, 4'h0, 32'h0,        16, 0, 0, 1, 0);
    vecs[12] = mkVec(1, 4'h0, 32'h0,        4'h4, 32'h00A50000, 16, 1, 1, 1, 0);
    vecs[13] = mkVec(1, 4'h1, 32'h00000033, 4'h1, 32'h00000033, 17, 1, 1, 1, 0);
    vecs[14] = mkVec(0, 4'h0, 32'h0,        4'h0, 32'h0,        17, 1, 1, 1, 0);
    vecs[15] = mkVec(0, 4'h0, 32'h0,        4'h0, 32'h0,        17, 1, 1, 0, 1);

    // Reset and check the idle state.
    reset = 1'b1;
    bus.i_enable = 0; bus.i_ref_valid = 0; bus.i_ref_data = 0;
    bus.i_dut_valid = 0; bus.i_dut_data = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkAllClear("reset");

    for (int k = 0; k < 16; k++) begin
      applyStimulus(vecs[k].en, vecs[k].rv, vecs[k].rd, vecs[k].dv, vecs[k].dd);
      checkOutput($sformatf("v%0d_match", k), 32'(bus.o_match_cnt), 32'(vecs[k].expMatch));
      checkOutput($sformatf("v%0d_mis", k),   32'(bus.o_mismatch_cnt), 32'(vecs[k].expMis));
      checkOutput($sformatf("v%0d_err", k),   32'(bus.o_error), 32'(vecs[k].expErr));
      checkOutput($sformatf("v%0d_busy", k),  32'(bus.o_busy), 32'(vecs[k].expBusy));
      checkOutput($sformatf("v%0d_done", k),  32'(bus.o_done), 32'(vecs[k].expDone));
    end
    checkOutput("cap_lane", 32'(bus.o_first_err_lane), 2);
    checkOutput("cap_exp",  32'(bus.o_first_err_exp), 32'h5A);
    checkOutput("cap_got",  32'(bus.o_first_err_got), 32'hA5);
    checkOutput("sat_match", 32'(satBus.o_match_cnt), 15);
    checkOutput("missing_clean", 32'(bus.o_missing_cnt), 0);
`ifdef PHY_SCOREBOARD_LANE_CNT_EN
    checkOutput("lane2_err_cnt", 32'(bus.o_lane_err_cnt[2*CW +: CW]), 1);
`endif

    // Overflow on lane 0, then a flush that can only end by timeout.
    applyStimulus(1, 4'h0, 32'h0, 4'h0, 32'h0);
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1, 4'h1, 32'(k), 4'h0, 32'h0);
      checkOutput($sformatf("ovf_after_push%0d", k), 32'(bus.o_overflow), (k == 5) ? 1 : 0);
    end
    applyStimulus(0, 4'h0, 32'h0, 4'h0, 32'h0);
    n = 0;
    seen = 0;
    while (n < 100 && !seen) begin
      applyStimulus(0, 4'h0, 32'h0, 4'h0, 32'h0);
      n++;
      if (bus.o_done) seen = 1;
    end
    checkOutput("flush_done_seen", 32'(seen), 1);
    checkOutput("flush_cycles", 32'(n), 64);
    checkOutput("missing_after_to", 32'(bus.o_missing_cnt), 4);
    checkOutput("mis_unchanged", 32'(bus.o_mismatch_cnt), 1);

    // Reset in the middle of a run clears everything and never pulses done.
    applyStimulus(1, 4'h0, 32'h0, 4'h0, 32'h0);
    applyStimulus(1, 4'h1, 32'h77, 4'h0, 32'h0);
    reset = 1'b1;
    applyStimulus(0, 4'h0, 32'h0, 4'h0, 32'h0);
    reset = 1'b0;
    checkAllClear("midrst");
    checkOutput("midrst_sat_match", 32'(satBus.o_match_cnt), 0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 4'h0, 32'h0, 4'h0, 32'h0);
      checkOutput($sformatf("midrst_nodone%0d", k), 32'(bus.o_done), 0);
    end

    // Dut beats on all lanes with empty FIFOs.
    applyStimulus(1, 4'h0, 32'h0, 4'h0, 32'h0);
    applyStimulus(1, 4'h0, 32'h0, 4'hF, 32'h44332211);
    checkOutput("empty_mis", 32'(bus.o_mismatch_cnt), 4);
    checkOutput("empty_match", 32'(bus.o_match_cnt), 0);
    checkOutput("empty_lane", 32'(bus.o_first_err_lane), 0);
    checkOutput("empty_exp", 32'(bus.o_first_err_exp), 0);
    checkOutput("empty_got", 32'(bus.o_first_err_got), 32'h11);
    checkOutput("empty_err", 32'(bus.o_error), 1);
`ifdef PHY_SCOREBOARD_LANE_CNT_EN
    for (int k = 0; k < NL; k++)
      checkOutput($sformatf("lane%0d_err_cnt", k), 32'(bus.o_lane_err_cnt[k*CW +: CW]), 1);
`endif

    // Fill lane 1, push and pop together while full, then drain in order.
    for (int k = 0; k < 4; k++)
      applyStimulus(1, 4'h2, 32'(32'h61 + k) << 8, 4'h0, 32'h0);
    applyStimulus(1, 4'h2, 32'h00006500, 4'h2, 32'h00006100);
    checkOutput("full_pp_ovf", 32'(bus.o_overflow), 0);
    checkOutput("full_pp_match", 32'(bus.o_match_cnt), 1);
    for (int k = 0; k < 4; k++)
      applyStimulus(1, 4'h0, 32'h0, 4'h2, 32'(32'h62 + k) << 8);
    checkOutput("drain_match", 32'(bus.o_match_cnt), 5);
    checkOutput("drain_mis", 32'(bus.o_mismatch_cnt), 4);
    checkOutput("drain_ovf", 32'(bus.o_overflow), 0);
    applyStimulus(0, 4'h0, 32'h0, 4'h0, 32'h0);
    applyStimulus(0, 4'h0, 32'h0, 4'h0, 32'h0);
    checkOutput("drain_done", 32'(bus.o_done), 1);
    checkOutput("drain_missing", 32'(bus.o_missing_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
